alu_pipe: RTL

- Parametrised, pipelined successor to the team's registered 4-bit ALU.
- Generalised to WIDTH bits; adds a valid/ready handshake on both sides, a full status-flag set, and an internal accumulator so ops can chain on the previous result.
- Sits between an operand source (switches, FSM or test harness) and a result consumer (LEDs, 7-seg driver, register file).

---
 rtl/alu_pipe_if.sv | 29 ++
 rtl/alu_pipe.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: valid/ready on both sides plus data and flags.
// The master side is the operand source and result consumer; the slave side is the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             negative;

  modport master (
    output in_valid, a, b, op, acc_sel, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow, negative
  );

  modport slave (
    input  in_valid, a, b, op, acc_sel, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow, negative
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, status flags and a chaining accumulator.
// S1 computes and updates the accumulator at capture; S2 holds the registered outputs.
module alu_pipe #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic      clk,
  input  logic      rst,
  alu_pipe_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             overflow;
  } alu_res_t;

  // Carry and overflow come from the (WIDTH+1)-bit intermediate; SUB reports borrow, not carry-out.
  function automatic alu_res_t alu_eval(
    input logic [2:0]              op_i,
    input logic signed [WIDTH-1:0] opa,
    input logic signed [WIDTH-1:0] opb
  );
    alu_res_t       r;
    logic [WIDTH:0] wide;
    r    = '0;
    wide = '0;
    case (op_i)
      OP_ADD: begin
        wide       = {1'b0, opa} + {1'b0, opb};
        r.res      = wide[WIDTH-1:0];
        r.carry    = wide[WIDTH];
        r.overflow = (opa[WIDTH-1] == opb[WIDTH-1]) && (r.res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        wide       = {1'b0, opa} + {1'b0, ~opb} + {{WIDTH{1'b0}}, 1'b1};
        r.res      = wide[WIDTH-1:0];
        r.carry    = ~wide[WIDTH];
        r.overflow = (opa[WIDTH-1] != opb[WIDTH-1]) && (r.res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_NOT: r.res = ~opa;
      OP_AND: r.res = opa & opb;
      OP_OR:  r.res = opa | opb;
      OP_XOR: r.res = opa ^ opb;
      OP_SLT: r.res = {{(WIDTH-1){1'b0}}, (opa < opb)};
      OP_EQ:  r.res = {{(WIDTH-1){1'b0}}, (opa == opb)};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic                    vld_p1;
  logic                    vld_p2;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] opa_p0;
  alu_res_t                eval_p0;
  logic                    accept;
  logic                    s2_free;
  logic                    s1_adv;

  logic [WIDTH-1:0] result_p1;
  logic             zero_p1;
  logic             carry_p1;
  logic             overflow_p1;
  logic             negative_p1;

  logic [WIDTH-1:0] result_p2;
  logic             zero_p2;
  logic             carry_p2;
  logic             overflow_p2;
  logic             negative_p2;

  assign s2_free      = !vld_p2 || bus.out_ready;
  assign s1_adv       = vld_p1 && s2_free;
  assign bus.in_ready = !rst && (!vld_p1 || s2_free);
  assign accept       = bus.in_valid && bus.in_ready;

  // ---- S0: operand select and combinational evaluate ----
  assign opa_p0  = bus.acc_sel ? acc : bus.a;
  assign eval_p0 = alu_eval(bus.op, opa_p0, bus.b);

  // ---- S1: pipeline control and accumulator ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      acc    <= ACC_RESET;
    end else begin
      if (accept) begin
        vld_p1 <= 1'b1;
        acc    <= eval_p0.res;
      end else if (s1_adv) begin
        vld_p1 <= 1'b0;
      end
      if (s2_free) begin
        vld_p2 <= vld_p1;
      end
    end
  end

  // S1 data is qualified by vld_p1, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      result_p1   <= eval_p0.res;
      zero_p1     <= (eval_p0.res == '0);
      carry_p1    <= eval_p0.carry;
      overflow_p1 <= eval_p0.overflow;
      negative_p1 <= eval_p0.res[WIDTH-1];
    end
  end

  // ---- S2: registered outputs, held while the consumer stalls ----
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p2   <= '0;
      zero_p2     <= 1'b0;
      carry_p2    <= 1'b0;
      overflow_p2 <= 1'b0;
      negative_p2 <= 1'b0;
    end else if (s1_adv) begin
      result_p2   <= result_p1;
      zero_p2     <= zero_p1;
      carry_p2    <= carry_p1;
      overflow_p2 <= overflow_p1;
      negative_p2 <= negative_p1;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.result    = result_p2;
  assign bus.zero      = zero_p2;
  assign bus.carry     = carry_p2;
  assign bus.overflow  = overflow_p2;
  assign bus.negative  = negative_p2;

endmodule
